io_cycle_master: RTL and testbench



---
 rtl/io_cycle_master_pkg.sv | 14 +
 rtl/io_cycle_master.sv | 165 ++++++++++++++++
 tb/tb_io_cycle_master.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_cycle_master_pkg.sv
// Shared types and limits for the Z80-style I/O cycle initiator.
package io_cycle_master_pkg;

  typedef enum logic [2:0] {
    IO_IDLE,
    IO_T1,
    IO_T2,
    IO_TW,
    IO_T3
  } io_cycle_state_t;

  localparam int unsigned IO_MAX_WAIT = 3;

endpackage

// File: rtl/io_cycle_master.sv
// Z80-style IORQ/RD/WR cycle generator advancing one T-state per clkcpu_ck strobe.
// Optional macro IO_CYCLE_MASTER_WAITN_EN adds the active-low bus_wait_n input.
module io_cycle_master
  import io_cycle_master_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        clkcpu_ck,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_d_out,
  output logic        bus_d_oe,
  input  logic [7:0]  bus_d_in,
`ifdef IO_CYCLE_MASTER_WAITN_EN
  input  logic        bus_wait_n,
`endif
  output logic        bus_ioreq,
  output logic        bus_rd,
  output logic        bus_wr
);

  if (WAIT_STATES > IO_MAX_WAIT) begin : g_wait_states_range
    $error("io_cycle_master: WAIT_STATES must be in 0..3");
  end

  localparam logic [1:0] WAIT_LOAD = (WAIT_STATES == 0) ? 2'd0 : 2'(WAIT_STATES - 1);

  io_cycle_state_t state_q, state_d;
  logic [1:0]  wait_cnt_q, wait_cnt_d;
  logic        is_out_q, is_out_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic [15:0] bus_a_q, bus_a_d;
  logic [7:0]  bus_d_out_q, bus_d_out_d;
  logic        bus_d_oe_q, bus_d_oe_d;
  logic        bus_ioreq_q, bus_ioreq_d;
  logic        bus_rd_q, bus_rd_d;
  logic        bus_wr_q, bus_wr_d;
  logic        wait_ok;

  // A low bus_wait_n at a T-state boundary in TW/T3 holds the cycle where it is.
`ifdef IO_CYCLE_MASTER_WAITN_EN
  assign wait_ok = bus_wait_n;
`else
  assign wait_ok = 1'b1;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    is_out_d    = is_out_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    bus_a_d     = bus_a_q;
    bus_d_out_d = bus_d_out_q;
    bus_d_oe_d  = bus_d_oe_q;
    bus_ioreq_d = bus_ioreq_q;
    bus_rd_d    = bus_rd_q;
    bus_wr_d    = bus_wr_q;

    unique case (state_q)
      IO_IDLE: begin
        req_ready_d = 1'b1;
        // A strobe coinciding with accept is ignored so T1 always waits for the next one.
        if (req_valid && req_ready_q) begin
          state_d     = IO_T1;
          req_ready_d = 1'b0;
          is_out_d    = req_wr;
          bus_a_d     = req_addr;
          bus_d_oe_d  = req_wr;
          if (req_wr) bus_d_out_d = req_data;
        end
      end
      IO_T1: begin
        if (clkcpu_ck) begin
          state_d     = IO_T2;
          bus_ioreq_d = 1'b1;
          bus_rd_d    = !is_out_q;
          bus_wr_d    = is_out_q;
        end
      end
      IO_T2: begin
        if (clkcpu_ck) begin
          if (WAIT_STATES != 0) begin
            state_d    = IO_TW;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = IO_T3;
          end
        end
      end
      IO_TW: begin
        if (clkcpu_ck && wait_ok) begin
          if (wait_cnt_q == 2'd0) state_d = IO_T3;
          else wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      IO_T3: begin
        if (clkcpu_ck && wait_ok) begin
          if (!is_out_q) rsp_data_d = bus_d_in;
          rsp_valid_d = 1'b1;
          bus_ioreq_d = 1'b0;
          bus_rd_d    = 1'b0;
          bus_wr_d    = 1'b0;
          bus_d_oe_d  = 1'b0;
          state_d     = IO_IDLE;
        end
      end
      default: state_d = IO_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk28) begin
    if (rst) begin
      state_q     <= IO_IDLE;
      wait_cnt_q  <= 2'd0;
      is_out_q    <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'hFF;
      bus_a_q     <= 16'h0000;
      bus_d_out_q <= 8'h00;
      bus_d_oe_q  <= 1'b0;
      bus_ioreq_q <= 1'b0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      is_out_q    <= is_out_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      bus_a_q     <= bus_a_d;
      bus_d_out_q <= bus_d_out_d;
      bus_d_oe_q  <= bus_d_oe_d;
      bus_ioreq_q <= bus_ioreq_d;
      bus_rd_q    <= bus_rd_d;
      bus_wr_q    <= bus_wr_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign bus_a     = bus_a_q;
  assign bus_d_out = bus_d_out_q;
  assign bus_d_oe  = bus_d_oe_q;
  assign bus_ioreq = bus_ioreq_q;
  assign bus_rd    = bus_rd_q;
  assign bus_wr    = bus_wr_q;

endmodule

// File: tb/tb_io_cycle_master.sv
// Directed bench for io_cycle_master: T-state accurate strobe widths, data capture, reset, back-to-back.
`timescale 1ns/1ps
module tb_io_cycle_master;

  logic        clk28 = 1'b0;
  logic        rst = 1'b1;
  logic        clkcpu_ck = 1'b0;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_data = 8'h00;
  logic [7:0]  bus_d_in = 8'hFF;
  logic        req_valid = 1'b0, req_valid_0 = 1'b0, req_valid_3 = 1'b0;
`ifdef IO_CYCLE_MASTER_WAITN_EN
  logic        bus_wait_n = 1'b1;
`endif

  logic        req_ready, rsp_valid, bus_d_oe, bus_ioreq, bus_rd, bus_wr;
  logic [7:0]  rsp_data, bus_d_out;
  logic [15:0] bus_a;
  logic        req_ready_0, rsp_valid_0, bus_d_oe_0, bus_ioreq_0, bus_rd_0, bus_wr_0;
  logic [7:0]  rsp_data_0, bus_d_out_0;
  logic [15:0] bus_a_0;
  logic        req_ready_3, rsp_valid_3, bus_d_oe_3, bus_ioreq_3, bus_rd_3, bus_wr_3;
  logic [7:0]  rsp_data_3, bus_d_out_3;
  logic [15:0] bus_a_3;

  int checks = 0;
  int fails  = 0;

  io_cycle_master #(.WAIT_STATES(1)) dut (
    .clk28(clk28), .rst(rst), .clkcpu_ck(clkcpu_ck),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bus_a(bus_a), .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe), .bus_d_in(bus_d_in),
`ifdef IO_CYCLE_MASTER_WAITN_EN
    .bus_wait_n(bus_wait_n),
`endif
    .bus_ioreq(bus_ioreq), .bus_rd(bus_rd), .bus_wr(bus_wr)
  );

  io_cycle_master #(.WAIT_STATES(0)) dut_w0 (
    .clk28(clk28), .rst(rst), .clkcpu_ck(clkcpu_ck),
    .req_valid(req_valid_0), .req_ready(req_ready_0), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid_0), .rsp_data(rsp_data_0),
    .bus_a(bus_a_0), .bus_d_out(bus_d_out_0), .bus_d_oe(bus_d_oe_0), .bus_d_in(bus_d_in),
`ifdef IO_CYCLE_MASTER_WAITN_EN
    .bus_wait_n(bus_wait_n),
`endif
    .bus_ioreq(bus_ioreq_0), .bus_rd(bus_rd_0), .bus_wr(bus_wr_0)
  );

  io_cycle_master #(.WAIT_STATES(3)) dut_w3 (
    .clk28(clk28), .rst(rst), .clkcpu_ck(clkcpu_ck),
    .req_valid(req_valid_3), .req_ready(req_ready_3), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid_3), .rsp_data(rsp_data_3),
    .bus_a(bus_a_3), .bus_d_out(bus_d_out_3), .bus_d_oe(bus_d_oe_3), .bus_d_in(bus_d_in),
`ifdef IO_CYCLE_MASTER_WAITN_EN
    .bus_wait_n(bus_wait_n),
`endif
    .bus_ioreq(bus_ioreq_3), .bus_rd(bus_rd_3), .bus_wr(bus_wr_3)
  );

  always #5 clk28 = ~clk28;

  // T-state strobe: one posedge in every eight.
  int ck_div = 0;
  always @(negedge clk28) begin
    ck_div    = (ck_div == 7) ? 0 : ck_div + 1;
    clkcpu_ck = (ck_div == 7);
  end

  // Per-instance activity counters, sampled mid-cycle.
  int ioreq_n = 0, rd_n = 0, wr_n = 0, oe_n = 0, rsp_n = 0;
  int ioreq0_n = 0, rd0_n = 0, wr0_n = 0, oe0_n = 0, rsp0_n = 0;
  int ioreq3_n = 0, rd3_n = 0, wr3_n = 0, oe3_n = 0, rsp3_n = 0;
  logic [7:0] last_dout = 8'h00, last_rsp = 8'h00, last_dout0 = 8'h00, last_dout3 = 8'h00;

  always @(negedge clk28) begin
    if (bus_ioreq) ioreq_n++;
    if (bus_rd) rd_n++;
    if (bus_wr) wr_n++;
    if (bus_d_oe) begin oe_n++; last_dout = bus_d_out; end
    if (rsp_valid) begin rsp_n++; last_rsp = rsp_data; end
    if (bus_ioreq_0) ioreq0_n++;
    if (bus_rd_0) rd0_n++;
    if (bus_wr_0) wr0_n++;
    if (bus_d_oe_0) begin oe0_n++; last_dout0 = bus_d_out_0; end
    if (rsp_valid_0) rsp0_n++;
    if (bus_ioreq_3) ioreq3_n++;
    if (bus_rd_3) rd3_n++;
    if (bus_wr_3) wr3_n++;
    if (bus_d_oe_3) begin oe3_n++; last_dout3 = bus_d_out_3; end
    if (rsp_valid_3) rsp3_n++;
  end

  task automatic tick();
    @(negedge clk28);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // which: 1 = WS1 instance, 0 = WS0 instance, 3 = WS3 instance.
  task automatic wait_rsp(input int which, input int target, input string name);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if ((which == 1 && rsp_n >= target) || (which == 0 && rsp0_n >= target) ||
          (which == 3 && rsp3_n >= target)) done = 1'b1;
      else tick();
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL %s: timeout waiting for rsp_valid, got none expected one", name);
    end
  endtask

  // Accept lands on a T-state boundary so T1 spans exactly one full T-state.
  task automatic issue_main(input logic wr, input logic [15:0] addr, input logic [7:0] data);
    bit ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      tick();
      if (clkcpu_ck && req_ready) ok = 1'b1;
    end
    req_wr = wr; req_addr = addr; req_data = data; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("accept_ready_low", req_ready, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 8'hFF);
    chk("rst_bus_a", bus_a, 16'h0000);
    chk("rst_bus_d_out", bus_d_out, 8'h00);
    chk("rst_bus_d_oe", bus_d_oe, 0);
    chk("rst_bus_ioreq", bus_ioreq, 0);
    chk("rst_bus_rd", bus_rd, 0);
    chk("rst_bus_wr", bus_wr, 0);
    rst = 1'b0;
    tick();
    chk("rst_ready_after", req_ready, 1);
  endtask

  task automatic test_out_7ffd();
    int s_io = ioreq_n, s_rd = rd_n, s_wr = wr_n, s_oe = oe_n, s_rsp = rsp_n;
    issue_main(1'b1, 16'h7FFD, 8'h15);
    wait_rsp(1, s_rsp + 1, "out_done");
    repeat (3) tick();
    chk("out_bus_a", bus_a, 16'h7FFD);
    chk("out_ioreq_len", ioreq_n - s_io, 24);
    chk("out_wr_len", wr_n - s_wr, 24);
    chk("out_oe_len", oe_n - s_oe, 32);
    chk("out_rd_never", rd_n - s_rd, 0);
    chk("out_d_out", last_dout, 8'h15);
    chk("out_rsp_count", rsp_n - s_rsp, 1);
    chk("out_rsp_data_hold", rsp_data, 8'hFF);
    chk("out_strobes_low", {bus_ioreq, bus_wr, bus_d_oe}, 3'b000);
  endtask

  task automatic test_in_00fe();
    int s_io = ioreq_n, s_rd = rd_n, s_wr = wr_n, s_oe = oe_n, s_rsp = rsp_n;
    bus_d_in = 8'hBF;
    issue_main(1'b0, 16'h00FE, 8'h00);
    wait_rsp(1, s_rsp + 1, "in_done");
    chk("in_rsp_on_pulse", last_rsp, 8'hBF);
    bus_d_in = 8'h00;
    repeat (3) tick();
    chk("in_rsp_data_hold", rsp_data, 8'hBF);
    chk("in_bus_a", bus_a, 16'h00FE);
    chk("in_rd_len", rd_n - s_rd, 24);
    chk("in_ioreq_len", ioreq_n - s_io, 24);
    chk("in_wr_never", wr_n - s_wr, 0);
    chk("in_oe_never", oe_n - s_oe, 0);
    chk("in_rsp_count", rsp_n - s_rsp, 1);
  endtask

  task automatic test_wait_states();
    int s_io0 = ioreq0_n, s_wr0 = wr0_n, s_rd0 = rd0_n, s_oe0 = oe0_n, s_r0 = rsp0_n;
    int s_io3 = ioreq3_n, s_wr3 = wr3_n, s_rd3 = rd3_n, s_oe3 = oe3_n, s_r3 = rsp3_n;
    bit ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      tick();
      if (clkcpu_ck && req_ready_0 && req_ready_3) ok = 1'b1;
    end
    req_wr = 1'b1; req_addr = 16'h00FE; req_data = 8'h07;
    req_valid_0 = 1'b1; req_valid_3 = 1'b1;
    tick();
    req_valid_0 = 1'b0; req_valid_3 = 1'b0;
    wait_rsp(0, s_r0 + 1, "ws0_done");
    wait_rsp(3, s_r3 + 1, "ws3_done");
    repeat (2) tick();
    chk("ws0_ioreq_len", ioreq0_n - s_io0, 16);
    chk("ws0_wr_len", wr0_n - s_wr0, 16);
    chk("ws0_oe_len", oe0_n - s_oe0, 24);
    chk("ws0_rd_never", rd0_n - s_rd0, 0);
    chk("ws0_d_out", last_dout0, 8'h07);
    chk("ws0_bus_a", bus_a_0, 16'h00FE);
    chk("ws0_rsp_data", rsp_data_0, 8'hFF);
    chk("ws3_ioreq_len", ioreq3_n - s_io3, 40);
    chk("ws3_wr_len", wr3_n - s_wr3, 40);
    chk("ws3_oe_len", oe3_n - s_oe3, 48);
    chk("ws3_rd_never", rd3_n - s_rd3, 0);
    chk("ws3_d_out", last_dout3, 8'h07);
    chk("ws3_bus_a", bus_a_3, 16'h00FE);
    chk("ws3_rsp_data", rsp_data_3, 8'hFF);
  endtask

  task automatic test_back_to_back();
    int s_rsp = rsp_n;
    int gap = 0, bad = 0;
    bit ok = 1'b0;
    bus_d_in = 8'h5A;
    for (int i = 0; i < 64 && !ok; i++) begin
      tick();
      if (req_ready) ok = 1'b1;
    end
    req_wr = 1'b1; req_addr = 16'h1FFD; req_data = 8'h04; req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      if (!req_ready) ok = 1'b1;
    end
    req_wr = 1'b0; req_addr = 16'hFFFF; req_data = 8'h00;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (rsp_valid) ok = 1'b1;
    end
    chk("b2b_first_done", ok, 1);
    if ({bus_ioreq, bus_rd, bus_wr, bus_d_oe} != 4'b0000) bad++;
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      tick();
      gap++;
      if (bus_a == 16'hFFFF) ok = 1'b1;
      else if ({bus_ioreq, bus_rd, bus_wr, bus_d_oe} != 4'b0000) bad++;
    end
    req_valid = 1'b0;
    wait_rsp(1, s_rsp + 2, "b2b_second_done");
    repeat (3) tick();
    chk("b2b_gap_min", gap >= 2, 1);
    chk("b2b_gap_strobes_low", bad, 0);
    chk("b2b_rsp_count", rsp_n - s_rsp, 2);
    chk("b2b_in_data", last_rsp, 8'h5A);
    chk("b2b_out_data", last_dout, 8'h04);
    chk("b2b_bus_a", bus_a, 16'hFFFF);
  endtask

  task automatic test_reset_mid();
    int s_rsp = rsp_n;
    issue_main(1'b1, 16'h7FFD, 8'h55);
    repeat (18) tick();
    chk("mid_in_cycle", {bus_ioreq, bus_wr}, 2'b11);
    rst = 1'b1;
    tick();
    chk("mid_ioreq_low", bus_ioreq, 0);
    chk("mid_wr_low", bus_wr, 0);
    chk("mid_oe_low", bus_d_oe, 0);
    chk("mid_rsp_low", rsp_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_ready_after", req_ready, 1);
    repeat (40) tick();
    chk("mid_no_rsp", rsp_n - s_rsp, 0);
  endtask

  task automatic test_waitn();
    int s_io = ioreq_n, s_wr = wr_n, s_oe = oe_n, s_rsp = rsp_n;
`ifdef IO_CYCLE_MASTER_WAITN_EN
    issue_main(1'b1, 16'hDFFD, 8'h33);
    repeat (17) tick();
    bus_wait_n = 1'b0;
    repeat (15) tick();
    bus_wait_n = 1'b1;
    wait_rsp(1, s_rsp + 1, "waitn_done");
    repeat (2) tick();
    chk("waitn_ioreq_len", ioreq_n - s_io, 40);
    chk("waitn_wr_len", wr_n - s_wr, 40);
    chk("waitn_oe_len", oe_n - s_oe, 48);
`else
    issue_main(1'b1, 16'hDFFD, 8'h33);
    wait_rsp(1, s_rsp + 1, "waitn_done");
    repeat (2) tick();
    chk("waitn_ioreq_len", ioreq_n - s_io, 24);
    chk("waitn_wr_len", wr_n - s_wr, 24);
    chk("waitn_oe_len", oe_n - s_oe, 32);
`endif
    chk("waitn_d_out", last_dout, 8'h33);
    chk("waitn_rsp_count", rsp_n - s_rsp, 1);
  endtask

  initial begin
    test_reset();
    test_out_7ffd();
    test_in_00fe();
    test_wait_states();
    test_back_to_back();
    test_reset_mid();
    test_waitn();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
